// File: rtl/uart_pkg.sv
// Shared UART definitions for the RS-232 transmitter and receiver:
// frame state encoding, data-width limits and default oversample rate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned UART_NBITS_MIN      = 5;
  localparam int unsigned UART_NBITS_MAX      = 8;
  localparam int unsigned UART_OVERSAMPLE_DEF = 16;

  function automatic logic [3:0] uart_clamp_nbits(input logic [3:0] n);
    logic [3:0] r;
    r = n;
    if (n < 4'(UART_NBITS_MIN)) r = 4'(UART_NBITS_MIN);
    if (n > 4'(UART_NBITS_MAX)) r = 4'(UART_NBITS_MAX);
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_baudcnt.sv
// Per-bit Tick counter: pulses bit_end on the cycle that carries the
// OVERSAMPLE-th Tick of the current bit period.
module uart_tx_baudcnt
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic Tick,
  output logic bit_end
);

  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  logic [3:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (Tick)    cnt <= (cnt == LAST) ? '0 : cnt + 4'd1;
  end

  assign bit_end = Tick && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rs232_tx.sv
// RS-232 frame transmitter: start bit, 5-8 data bits LSB first, optional
// parity (macro UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_rs232_tx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       TxEn,
  input  logic       TxStart,
`ifdef UART_TX_PARITY_EN
  input  logic       ParOdd,
`endif
  input  logic [7:0] TxData,
  input  logic [3:0] NBits,
  output logic       Tx,
  output logic       TxBusy,
  output logic       TxDone
);

  uart_state_e state, state_n;
  logic [7:0]  shreg, shreg_n;
  logic [3:0]  nbits_q, nbits_n, nbits_c;
  logic [2:0]  bitcnt, bitcnt_n;
  logic        tx_n, busy_n, done_n;
  logic        bit_end, clr;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_n;
  logic [7:0]  mask;
`endif

  assign nbits_c = uart_clamp_nbits(NBits);
  // Counter held cleared in IDLE so a Tick on the accept edge is not counted
  assign clr = (state == IDLE) || !TxEn;

  uart_tx_baudcnt #(.OVERSAMPLE(OVERSAMPLE)) u_baudcnt (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .clr     (clr),
    .Tick    (Tick),
    .bit_end (bit_end)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    nbits_n  = nbits_q;
    bitcnt_n = bitcnt;
    done_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n    = par_q;
    mask     = ~(8'hFF << nbits_c);
`endif
    case (state)
      IDLE: begin
        if (TxStart && TxEn) begin
          state_n  = START;
          shreg_n  = TxData;
          nbits_n  = nbits_c;
          bitcnt_n = '0;
`ifdef UART_TX_PARITY_EN
          par_n    = (^(TxData & mask)) ^ ParOdd;
`endif
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if ({1'b0, bitcnt} == nbits_q - 4'd1) begin
            bitcnt_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n  = PARITY;
`else
            state_n  = STOP;
`endif
          end else begin
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_n = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (bitcnt == 3'(STOP_BITS - 1)) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            done_n   = 1'b1;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides completion
    if (state != IDLE && !TxEn) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      done_n   = 1'b0;
    end

    // Outputs are registered from the next state so levels change on the bit-end edge
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_q;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      nbits_q <= '0;
      bitcnt  <= '0;
      Tx      <= 1'b1;
      TxBusy  <= 1'b0;
      TxDone  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      nbits_q <= nbits_n;
      bitcnt  <= bitcnt_n;
      Tx      <= tx_n;
      TxBusy  <= busy_n;
      TxDone  <= done_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) par_q <= 1'b0;
    else        par_q <= par_n;
  end
`endif

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Directed bench for uart_rs232_tx: frame levels tick by tick, clamping,
// back-to-back, abort and asynchronous reset.
module tb_uart_rs232_tx;

  logic       Clk = 1'b0;
  logic       Rst_n, Tick, TxEn, TxStart;
  logic [7:0] TxData;
  logic [3:0] NBits;
  logic       Tx, TxBusy, TxDone;
`ifdef UART_TX_PARITY_EN
  logic       ParOdd;
`endif

  int unsigned vec  = 0;
  int unsigned errs = 0;

  uart_rs232_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Tick    (Tick),
    .TxEn    (TxEn),
    .TxStart (TxStart),
`ifdef UART_TX_PARITY_EN
    .ParOdd  (ParOdd),
`endif
    .TxData  (TxData),
    .NBits   (NBits),
    .Tx      (Tx),
    .TxBusy  (TxBusy),
    .TxDone  (TxDone)
  );

  initial forever #5 Clk = ~Clk;

  // Tick high at every other rising edge
  initial begin
    Tick = 1'b0;
    forever begin
      @(negedge Clk);
      Tick = ~Tick;
    end
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: {Tx,TxBusy,TxDone} observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge Clk);
      seen = Tick;
    end
    if (!seen) begin
      vec++;
      errs++;
      $error("FAIL tick_timeout: observed %b expected 1", seen);
    end
    #1;
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [3:0] nb, input logic phase);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #1;
      if (Tick == phase) break;
    end
    TxData  = d;
    NBits   = nb;
    TxStart = 1'b1;
    @(posedge Clk);
    #1;
    TxStart = 1'b0;
    chk("accept", {Tx, TxBusy, TxDone}, 3'b010);
  endtask

  task automatic run_frame(input logic [7:0] d, input int n, input bit mid_pulse,
                           input bit b2b, input logic [7:0] nxt);
    logic lv [0:11];
    logic p;
    int   nb;
    lv[0] = 1'b0;
    p     = 1'b0;
    for (int i = 0; i < n; i++) begin
      lv[1+i] = d[i];
      p       = p ^ d[i];
    end
    nb = n + 1;
`ifdef UART_TX_PARITY_EN
    lv[nb] = p ^ ParOdd;
    nb++;
`endif
    lv[nb] = 1'b1;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int t = 1; t < 16; t++) begin
        wait_tick();
        chk($sformatf("bit%0d_hold", b), {Tx, TxBusy, TxDone}, {lv[b], 2'b10});
        if (mid_pulse && b == 3 && t == 4) begin
          TxStart = 1'b1;
          TxData  = 8'h00;
        end
        if (mid_pulse && b == 3 && t == 5) TxStart = 1'b0;
        if (b2b && b == nb - 1 && t == 1) begin
          TxStart = 1'b1;
          TxData  = nxt;
        end
      end
      wait_tick();
      if (b < nb - 1) chk($sformatf("bit%0d_edge", b), {Tx, TxBusy, TxDone}, {lv[b+1], 2'b10});
      else            chk("done", {Tx, TxBusy, TxDone}, 3'b101);
    end
    @(posedge Clk);
    #1;
    if (b2b) begin
      chk("b2b_start", {Tx, TxBusy, TxDone}, 3'b010);
      TxStart = 1'b0;
    end else begin
      chk("idle_after", {Tx, TxBusy, TxDone}, 3'b100);
    end
  endtask

  initial begin
    Rst_n   = 1'b0;
    TxEn    = 1'b1;
    TxStart = 1'b0;
    TxData  = 8'h00;
    NBits   = 4'd8;
`ifdef UART_TX_PARITY_EN
    ParOdd  = 1'b0;
`endif
    #12;
    chk("reset", {Tx, TxBusy, TxDone}, 3'b100);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("idle", {Tx, TxBusy, TxDone}, 3'b100);

    // 0xA5, accept edge coincides with a Tick
    start_frame(8'hA5, 4'd8, 1'b1);
    run_frame(8'hA5, 8, 1'b0, 1'b0, 8'h00);

    start_frame(8'hC1, 4'd7, 1'b0);
    run_frame(8'hC1, 7, 1'b0, 1'b0, 8'h00);

    // NBits clamped up to 5 and down to 8
    start_frame(8'hFA, 4'd2, 1'b0);
    run_frame(8'hFA, 5, 1'b0, 1'b0, 8'h00);
    start_frame(8'h81, 4'd15, 1'b1);
    run_frame(8'h81, 8, 1'b0, 1'b0, 8'h00);

    // Back-to-back with an ignored mid-frame request
    start_frame(8'h55, 4'd8, 1'b0);
    run_frame(8'h55, 8, 1'b1, 1'b1, 8'h0F);
    run_frame(8'h0F, 8, 1'b0, 1'b0, 8'h00);

    // Abort during data bit 3 (level 0)
    start_frame(8'hA5, 4'd8, 1'b1);
    repeat (69) wait_tick();
    chk("abort_pre", {Tx, TxBusy, TxDone}, 3'b010);
    TxEn = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort", {Tx, TxBusy, TxDone}, 3'b100);
    repeat (40) @(posedge Clk);
    #1;
    chk("abort_quiet", {Tx, TxBusy, TxDone}, 3'b100);
    TxEn = 1'b1;
    start_frame(8'h3C, 4'd8, 1'b0);
    run_frame(8'h3C, 8, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset during data bit 1 (level 0)
    start_frame(8'hA5, 4'd8, 1'b0);
    repeat (35) wait_tick();
    chk("rst_pre", {Tx, TxBusy, TxDone}, 3'b010);
    Rst_n = 1'b0;
    #1;
    chk("async_rst", {Tx, TxBusy, TxDone}, 3'b100);
    @(negedge Clk);
    Rst_n = 1'b1;
    start_frame(8'hFF, 4'd8, 1'b1);
    run_frame(8'hFF, 8, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
